player_hit_ctl: RTL

Player-side receiver for enemy missile positions. Takes the missile coordinates published by up to three enemy groups (`en_x_missile` / `en_y_missile`) and the player sprite position, and detects rectangle overlap. It owns the player's life counter, the post-hit invulnerability window with sprite blinking, and the game-over flag. It sits between the enemy groups and the player draw/control path; `player_on` gates the player sprite and `game_over` feeds the top-level game controller.

---
 rtl/player_hit_ctl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/player_hit_ctl.sv
// player_hit_ctl: enemy-missile vs player overlap detection, life counter, post-hit
// invulnerability window and game-over flag. Define PLAYER_HIT_BLINK_EN to blink the sprite while invulnerable.
module player_hit_ctl #(
    parameter int PLAYER_W      = 48,
    parameter int PLAYER_H      = 32,
    parameter int MISSILE_W     = 4,
    parameter int MISSILE_H     = 12,
    parameter int SCREEN_H      = 768,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        restart,
    input  logic [10:0] xpos_player,
    input  logic [10:0] ypos_player,
    input  logic [10:0] en_x_missile_1,
    input  logic [10:0] en_y_missile_1,
    input  logic [10:0] en_x_missile_2,
    input  logic [10:0] en_y_missile_2,
    input  logic [10:0] en_x_missile_3,
    input  logic [10:0] en_y_missile_3,
    output logic [2:0]  lives,
    output logic        player_on,
    output logic        hit_pulse,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    localparam logic [11:0] L_PW    = 12'(PLAYER_W);
    localparam logic [11:0] L_PH    = 12'(PLAYER_H);
    localparam logic [11:0] L_MW    = 12'(MISSILE_W);
    localparam logic [11:0] L_MH    = 12'(MISSILE_H);
    localparam logic [11:0] L_SH    = 12'(SCREEN_H);
    localparam logic [2:0]  L_LIVES = 3'(LIVES_INIT);
    localparam logic [7:0]  L_INV   = 8'(INVULN_FRAMES);

    // Coordinates are widened to 12 bits so edge sums near 2047 cannot wrap.
    function automatic logic f_overlap(input logic [10:0] xm, input logic [10:0] ym,
                                       input logic [10:0] xp, input logic [10:0] yp);
        logic [11:0] xm12;
        logic [11:0] ym12;
        logic [11:0] xp12;
        logic [11:0] yp12;
        xm12 = {1'b0, xm};
        ym12 = {1'b0, ym};
        xp12 = {1'b0, xp};
        yp12 = {1'b0, yp};
        return (ym12 < L_SH) &&
               (xm12 + L_MW > xp12) && (xm12 < xp12 + L_PW) &&
               (ym12 + L_MH > yp12) && (ym12 < yp12 + L_PH);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_ov;
    logic        r_hit_any;
    logic        r_vs_prev;
    logic [2:0]  r_lives;
    logic        r_player_on;
    logic        r_hit_pulse;
    logic        r_game_over;
    logic [7:0]  r_inv_cnt;
    logic [2:0]  w_lives_nxt;
    logic        w_player_on_nxt;
    logic        w_hit_pulse_nxt;
    logic        w_game_over_nxt;
    logic [7:0]  w_inv_cnt_nxt;
    logic [2:0]  w_ov;
    logic        w_frame_tick;
`ifdef PLAYER_HIT_BLINK_EN
    localparam logic [7:0] L_BLINK_LAST = 8'(BLINK_FRAMES - 1);
    logic [7:0]  r_blink_cnt;
    logic [7:0]  w_blink_cnt_nxt;
`endif

    assign w_ov = {f_overlap(en_x_missile_3, en_y_missile_3, xpos_player, ypos_player),
                   f_overlap(en_x_missile_2, en_y_missile_2, xpos_player, ypos_player),
                   f_overlap(en_x_missile_1, en_y_missile_1, xpos_player, ypos_player)};
    assign w_frame_tick = vsync_in & ~r_vs_prev;

    // Overlap and hit-combine pipeline stages plus vsync edge history.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_ov      <= 3'b000;
            r_hit_any <= 1'b0;
            r_vs_prev <= 1'b0;
        end else if (restart) begin
            r_ov      <= 3'b000;
            r_hit_any <= 1'b0;
            r_vs_prev <= vsync_in;
        end else begin
            r_ov      <= w_ov;
            r_hit_any <= |r_ov;
            r_vs_prev <= vsync_in;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state     <= ST_ALIVE;
            r_lives     <= L_LIVES;
            r_player_on <= 1'b1;
            r_hit_pulse <= 1'b0;
            r_game_over <= 1'b0;
            r_inv_cnt   <= 8'd0;
`ifdef PLAYER_HIT_BLINK_EN
            r_blink_cnt <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_player_on <= w_player_on_nxt;
            r_hit_pulse <= w_hit_pulse_nxt;
            r_game_over <= w_game_over_nxt;
            r_inv_cnt   <= w_inv_cnt_nxt;
`ifdef PLAYER_HIT_BLINK_EN
            r_blink_cnt <= w_blink_cnt_nxt;
`endif
        end
    end

    // Next-state logic; restart overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = ST_ALIVE;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (r_hit_any) begin
                        w_state_nxt = (r_lives > 3'd1) ? ST_INVULN : ST_DEAD;
                    end else begin
                        w_state_nxt = ST_ALIVE;
                    end
                end
                ST_INVULN: begin
                    if (w_frame_tick && (r_inv_cnt <= 8'd1)) begin
                        w_state_nxt = ST_ALIVE;
                    end else begin
                        w_state_nxt = ST_INVULN;
                    end
                end
                ST_DEAD:  w_state_nxt = ST_DEAD;
                default:  w_state_nxt = ST_ALIVE;
            endcase
        end
    end

    // Next values of lives, counters and sprite/status outputs.
    always_comb begin
        w_lives_nxt     = r_lives;
        w_player_on_nxt = r_player_on;
        w_hit_pulse_nxt = 1'b0;
        w_game_over_nxt = r_game_over;
        w_inv_cnt_nxt   = r_inv_cnt;
`ifdef PLAYER_HIT_BLINK_EN
        w_blink_cnt_nxt = r_blink_cnt;
`endif
        if (restart) begin
            w_lives_nxt     = L_LIVES;
            w_player_on_nxt = 1'b1;
            w_game_over_nxt = 1'b0;
            w_inv_cnt_nxt   = 8'd0;
`ifdef PLAYER_HIT_BLINK_EN
            w_blink_cnt_nxt = 8'd0;
`endif
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (r_hit_any) begin
                        w_hit_pulse_nxt = 1'b1;
                        if (r_lives > 3'd1) begin
                            w_lives_nxt   = r_lives - 3'd1;
                            w_inv_cnt_nxt = L_INV;
`ifdef PLAYER_HIT_BLINK_EN
                            w_blink_cnt_nxt = 8'd0;
                            w_player_on_nxt = 1'b0;
`else
                            w_player_on_nxt = 1'b1;
`endif
                        end else begin
                            w_lives_nxt     = 3'd0;
                            w_game_over_nxt = 1'b1;
                            w_player_on_nxt = 1'b0;
                        end
                    end else begin
                        w_hit_pulse_nxt = 1'b0;
                    end
                end
                ST_INVULN: begin
                    if (w_frame_tick) begin
                        if (r_inv_cnt <= 8'd1) begin
                            w_inv_cnt_nxt   = 8'd0;
                            w_player_on_nxt = 1'b1;
`ifdef PLAYER_HIT_BLINK_EN
                            w_blink_cnt_nxt = 8'd0;
`endif
                        end else begin
                            w_inv_cnt_nxt = r_inv_cnt - 8'd1;
`ifdef PLAYER_HIT_BLINK_EN
                            if (r_blink_cnt == L_BLINK_LAST) begin
                                w_blink_cnt_nxt = 8'd0;
                                w_player_on_nxt = ~r_player_on;
                            end else begin
                                w_blink_cnt_nxt = r_blink_cnt + 8'd1;
                            end
`else
                            w_player_on_nxt = 1'b1;
`endif
                        end
                    end else begin
                        w_inv_cnt_nxt = r_inv_cnt;
                    end
                end
                ST_DEAD: w_hit_pulse_nxt = 1'b0;
                default: w_hit_pulse_nxt = 1'b0;
            endcase
        end
    end

    assign lives     = r_lives;
    assign player_on = r_player_on;
    assign hit_pulse = r_hit_pulse;
    assign game_over = r_game_over;

endmodule
